// File: rtl/aes128_decrypt_iterative.sv
// aes128_decrypt_iterative
//
// Iterative AES-128 inverse cipher (FIPS-197). One ciphertext block and the
// cipher key are captured per transaction. The core first runs the forward
// key expansion to reach round key 10. It then executes the inverse rounds,
// one per clock, and rolls the key schedule backwards alongside them, so no
// round-key storage is needed.
//
// Ports:
//   clk            system clock, rising-edge active
//   rst_n          asynchronous active-low reset
//   start          request, only sampled while idle
//   ciphertext_in  ciphertext block, bit 127 is byte 0
//   secret_key     cipher key, same byte order
//   plaintext_out  recovered plaintext, held until the next completion
//   busy           high while a transaction is in flight
//   done           one-cycle pulse when plaintext_out is updated
module aes128_decrypt_iterative #(
    parameter int N  = 128,
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] ciphertext_in,
    input  logic [N-1:0] secret_key,
    output logic [N-1:0] plaintext_out,
    output logic         busy,
    output logic         done
);

    typedef enum logic [2:0] {
        IDLE,
        KEXP,
        INIT,
        ROUND,
        FINAL
    } fsm_e;

    // The same count value (NR-1) ends key expansion and seeds the round
    // countdown.
    localparam logic [3:0] CNT_LAST = 4'(NR - 1);

    fsm_e         fsm_q, fsm_d;
    logic [127:0] data_q, data_d;
    logic [127:0] key_q, key_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] pt_q, pt_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic [127:0] inv_sr_sb;
    logic [127:0] round_out;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1 (0x11b)
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return r;
    endfunction

    // Multiplicative inverse as a^254 (bits 1..7 of the exponent are set).
    // This maps 0 to 0, which is the convention the S-box needs.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gmul(r, p);
            p = gmul(p, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // The S-boxes are derived arithmetically rather than tabulated:
    // forward = affine(inverse(a)), and inverse = inverse(inv_affine(a)).
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return ginv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        logic [31:0] r;
        r = {w[23:0], w[31:24]};
        return {sbox(r[31:24]), sbox(r[23:16]), sbox(r[15:8]), sbox(r[7:0])};
    endfunction

    // Byte b of the block sits at row b%4, column b/4.
    // Inverse ShiftRows moves row r right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * (r + 4 * ((c - r + 4) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int b = 0; b < 16; b++) begin
            o[127 - 8 * b -: 8] = inv_sbox(s[127 - 8 * b -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            o[127 - 32 * c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119 - 32 * c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111 - 32 * c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103 - 32 * c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Undo one forward step. The previous w3 must be rebuilt first,
    // because the previous w0 depends on SubWord of it.
    function automatic logic [127:0] key_back(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] p0, p1, p2, p3;
        p3 = k[31:0] ^ k[63:32];
        p2 = k[63:32] ^ k[95:64];
        p1 = k[95:64] ^ k[127:96];
        p0 = k[127:96] ^ sub_rot_word(p3) ^ {rc, 24'h0};
        return {p0, p1, p2, p3};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Inverse of xtime. An odd value can only have come from a
    // reduced shift, so fold 0x1b back out and restore the top bit.
    function automatic logic [7:0] inv_xtime(input logic [7:0] b);
        return b[0] ? (((b ^ 8'h1b) >> 1) | 8'h80) : (b >> 1);
    endfunction

    assign inv_sr_sb = inv_sub_bytes(inv_shift_rows(data_q));
    assign round_out = inv_mix_columns(inv_sr_sb ^ key_q);

    // Next-state and datapath control. Every _d holds its _q by default,
    // except done, which falls back to 0 so that it can only pulse.
    // Key expansion leaves rcon at its last-used value (0x36) instead of
    // advancing it. The backward walk can then reuse rcon before stepping it
    // down.
    always_comb begin
        fsm_d  = fsm_q;
        data_d = data_q;
        key_d  = key_q;
        rcon_d = rcon_q;
        cnt_d  = cnt_q;
        pt_d   = pt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (start) begin
                    data_d = ciphertext_in;
                    key_d  = secret_key;
                    rcon_d = 8'h01;
                    cnt_d  = 4'd0;
                    busy_d = 1'b1;
                    fsm_d  = KEXP;
                end
            end
            KEXP: begin
                key_d = key_fwd(key_q, rcon_q);
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    fsm_d = INIT;
                end else begin
                    rcon_d = xtime(rcon_q);
                end
            end
            INIT: begin
                data_d = data_q ^ key_q;
                key_d  = key_back(key_q, rcon_q);
                rcon_d = inv_xtime(rcon_q);
                cnt_d  = CNT_LAST;
                fsm_d  = ROUND;
            end
            ROUND: begin
                data_d = round_out;
                key_d  = key_back(key_q, rcon_q);
                rcon_d = inv_xtime(rcon_q);
                cnt_d  = cnt_q - 4'd1;
                if (cnt_q == 4'd1) fsm_d = FINAL;
            end
            FINAL: begin
                pt_d   = inv_sr_sb ^ key_q;
                done_d = 1'b1;
                busy_d = 1'b0;
                fsm_d  = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    // State register; reset aborts any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q  <= IDLE;
            data_q <= '0;
            key_q  <= '0;
            rcon_q <= '0;
            cnt_q  <= '0;
            pt_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            data_q <= data_d;
            key_q  <= key_d;
            rcon_q <= rcon_d;
            cnt_q  <= cnt_d;
            pt_q   <= pt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign plaintext_out = pt_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_aes128_decrypt_iterative.sv
// tb_aes128_decrypt_iterative
//
// Bench for aes128_decrypt_iterative using directed FIPS-197 vectors.
// The stimulus side pushes each expected plaintext and its expected done
// cycle into a scoreboard queue. A monitor pops and compares an entry
// whenever done is seen.
module tb_aes128_decrypt_iterative;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    typedef struct {
        logic [127:0] pt;
        int           due;
        string        name;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] ciphertext_in;
    logic [127:0] secret_key;
    logic [127:0] plaintext_out;
    logic         busy;
    logic         done;

    int   checks;
    int   failures;
    int   cyc;
    exp_t sb[$];
    exp_t mon_e;

    aes128_decrypt_iterative #(
        .N (128),
        .NR(10)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .ciphertext_in(ciphertext_in),
        .secret_key   (secret_key),
        .plaintext_out(plaintext_out),
        .busy         (busy),
        .done         (done)
    );

    // Free-running clock with a 10 ns period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count rising edges so latencies can be checked at the falling edge
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Called at a falling edge. Drives a one-cycle start pulse and records
    // the expected result. The accepting edge is the next rising edge, and
    // done becomes visible 22 falling edges after this one.
    task automatic applyStimulus(input logic [127:0] ct, input logic [127:0] key,
                                 input logic [127:0] pt, input string name);
        exp_t e;
        start         = 1'b1;
        ciphertext_in = ct;
        secret_key    = key;
        e.pt   = pt;
        e.due  = cyc + 22;
        e.name = name;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int g;
        g = 0;
        while (sb.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        checkOutput({name, "_drained"}, 128'(sb.size()), 128'd0);
        sb.delete();
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_done", 128'(done), 128'd0);
            end else begin
                mon_e = sb.pop_front();
                checkOutput({mon_e.name, "_pt"}, plaintext_out, mon_e.pt);
                checkOutput({mon_e.name, "_latency"}, 128'(cyc), 128'(mon_e.due));
            end
        end
    end

    // Watchdog against a hung run
    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence
    initial begin
        int n;
        int g;
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        start         = 1'b0;
        ciphertext_in = '0;
        secret_key    = '0;

        repeat (3) @(negedge clk);
        checkOutput("reset_pt", plaintext_out, 128'd0);
        checkOutput("reset_busy", 128'(busy), 128'd0);
        checkOutput("reset_done", 128'(done), 128'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // C.1 vector with busy-width measurement
        $display("[TB] C.1 vector");
        applyStimulus(C1_CT, C1_KEY, C1_PT, "c1");
        n = 0;
        g = 0;
        while (!done && g < 60) begin
            if (busy) n++;
            @(negedge clk);
            g++;
        end
        checkOutput("c1_busy_cycles", 128'(n), 128'd21);
        checkOutput("c1_busy_at_done", 128'(busy), 128'd0);
        waitDrain("c1");

        // Appendix B vector
        $display("[TB] Appendix B vector");
        @(negedge clk);
        applyStimulus(B_CT, B_KEY, B_PT, "b");
        waitDrain("b");

        // A second start while busy must be ignored
        $display("[TB] busy rejection");
        @(negedge clk);
        applyStimulus(C1_CT, C1_KEY, C1_PT, "rej_c1");
        repeat (3) @(negedge clk);
        start         = 1'b1;
        ciphertext_in = B_CT;
        secret_key    = B_KEY;
        @(negedge clk);
        start = 1'b0;
        waitDrain("rej_c1");
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy) n++;
        end
        checkOutput("rej_no_restart_busy", 128'(n), 128'd0);

        // Back-to-back: the next start is issued in the done cycle
        $display("[TB] back-to-back");
        @(negedge clk);
        applyStimulus(C1_CT, C1_KEY, C1_PT, "b2b_c1");
        g = 0;
        while (!done && g < 60) begin
            @(negedge clk);
            g++;
        end
        checkOutput("b2b_first_done_seen", 128'(done), 128'd1);
        applyStimulus(B_CT, B_KEY, B_PT, "b2b_b");
        waitDrain("b2b");

        // Reset in the middle of a transaction
        $display("[TB] reset mid-operation");
        @(negedge clk);
        start         = 1'b1;
        ciphertext_in = B_CT;
        secret_key    = B_KEY;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_pt", plaintext_out, 128'd0);
        checkOutput("midrst_busy", 128'(busy), 128'd0);
        checkOutput("midrst_done", 128'(done), 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (25) begin
            @(negedge clk);
            if (busy) n++;
        end
        checkOutput("midrst_idle_busy", 128'(n), 128'd0);
        applyStimulus(C1_CT, C1_KEY, C1_PT, "post_rst_c1");
        waitDrain("post_rst_c1");

        // Inputs change every cycle after acceptance
        $display("[TB] input hold-off");
        @(negedge clk);
        applyStimulus(B_CT, B_KEY, B_PT, "holdoff");
        repeat (25) begin
            ciphertext_in = {$urandom, $urandom, $urandom, $urandom};
            secret_key    = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
        end
        waitDrain("holdoff");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
